// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the polynomial arithmetic block (ML-KEM, Q = 3329).
package poly_arith_pkg;

    localparam int COEFF_W = 12;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [6:0]         pair_addr_t;

    localparam coeff_t     Q          = 12'd3329;
    localparam coeff_t     COEFF_ZERO = 12'd0;
    localparam int         N_PAIRS    = 128;
    localparam pair_addr_t LAST_PAIR  = 7'd127;
    localparam logic [7:0] FULL_CNT   = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } basemul_state_e;

    function automatic logic is_last_pair(input pair_addr_t idx);
        return idx == LAST_PAIR;
    endfunction

endpackage

// File: rtl/mod_add_q.sv
// Combinational (a + b) mod Q for a, b in [0, Q).
// Only present when BASEMUL_ACCUMULATE_EN is defined.
`ifdef BASEMUL_ACCUMULATE_EN
module mod_add_q
    import poly_arith_pkg::*;
(
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t sum
);

    logic [COEFF_W:0] raw_s;

    // a + b < 2Q, so a single conditional subtract lands in [0, Q).
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b};
        if (raw_s >= {1'b0, Q}) begin
            sum = coeff_t'(raw_s - {1'b0, Q});
        end else begin
            sum = raw_s[COEFF_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/poly_basemul_ctrl.sv
// Sequences one NTT-domain polynomial product through base_case_mul into result memory C.
// Optional feature macro: BASEMUL_ACCUMULATE_EN (adds acc_i/c_rd_i, C += A*B).
module poly_basemul_ctrl
    import poly_arith_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
`ifdef BASEMUL_ACCUMULATE_EN
    input  logic         acc_i,
    input  coeff_t [1:0] c_rd_i,
`endif
    output logic         busy_o,
    output logic         done_o,
    output logic         rd_en_o,
    output pair_addr_t   rd_addr_o,
    input  coeff_t [1:0] a_rd_i,
    input  coeff_t [1:0] b_rd_i,
    input  coeff_t       zeta_rd_i,
    output logic         mul_valid_o,
    output coeff_t       mul_a0_o,
    output coeff_t       mul_a1_o,
    output coeff_t       mul_b0_o,
    output coeff_t       mul_b1_o,
    output coeff_t       mul_zeta_o,
    input  logic         mul_valid_i,
    input  coeff_t       mul_c0_i,
    input  coeff_t       mul_c1_i,
    output logic         wr_en_o,
    output pair_addr_t   wr_addr_o,
    output coeff_t [1:0] wr_data_o,
    output logic         err_o
);

    basemul_state_e    state_r, state_s;
    logic              rd_en_r, rd_en_s;
    pair_addr_t        rd_addr_r, rd_addr_s;
    pair_addr_t        wr_idx_r, wr_idx_s;
    logic [7:0]        wr_cnt_r, wr_cnt_s;
    logic              busy_r, done_r;
    logic              err_r, err_s;
    logic              wr_fire_s;
    logic              in_run_s;
    logic [RD_LAT-1:0] rd_pipe_r;

`ifdef BASEMUL_ACCUMULATE_EN
    logic              acc_r, acc_s;
    coeff_t [1:0]      c_pipe_r [MUL_LAT];
    coeff_t            sum0_s, sum1_s;

    mod_add_q u_add0 (.a(c_pipe_r[MUL_LAT-1][0]), .b(mul_c0_i), .sum(sum0_s));
    mod_add_q u_add1 (.a(c_pipe_r[MUL_LAT-1][1]), .b(mul_c1_i), .sum(sum1_s));
`endif

    // Next-state, counters and error flag.
    always_comb begin
        state_s   = state_r;
        rd_en_s   = 1'b0;
        rd_addr_s = rd_addr_r;
        wr_idx_s  = wr_idx_r;
        wr_cnt_s  = wr_cnt_r;
        err_s     = err_r;
        wr_fire_s = 1'b0;
`ifdef BASEMUL_ACCUMULATE_EN
        acc_s     = acc_r;
`endif
        in_run_s  = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);

        // Results outside a run are never written; they only flag an error.
        if (mul_valid_i && in_run_s && rst_n) begin
            wr_fire_s = 1'b1;
            wr_cnt_s  = wr_cnt_r + 8'd1;
            if (is_last_pair(wr_idx_r)) begin
                wr_idx_s = wr_idx_r;
            end else begin
                wr_idx_s = wr_idx_r + 7'd1;
            end
        end else if (mul_valid_i && !in_run_s) begin
            err_s = 1'b1;
        end else begin
            wr_fire_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s   = ST_ISSUE;
                    rd_en_s   = 1'b1;
                    rd_addr_s = 7'd0;
                    wr_idx_s  = 7'd0;
                    wr_cnt_s  = 8'd0;
`ifdef BASEMUL_ACCUMULATE_EN
                    acc_s     = acc_i;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (is_last_pair(rd_addr_r)) begin
                    state_s = ST_DRAIN;
                    rd_en_s = 1'b0;
                end else begin
                    rd_en_s   = 1'b1;
                    rd_addr_s = rd_addr_r + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (wr_fire_s && is_last_pair(wr_idx_r)) begin
                    state_s = ST_DONE;
                    err_s   = err_s | (wr_cnt_s != FULL_CNT);
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, registered status outputs and the read-latency pipes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rd_en_r   <= 1'b0;
            rd_addr_r <= 7'd0;
            wr_idx_r  <= 7'd0;
            wr_cnt_r  <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            rd_pipe_r <= {RD_LAT{1'b0}};
`ifdef BASEMUL_ACCUMULATE_EN
            acc_r     <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) begin
                c_pipe_r[k] <= {COEFF_ZERO, COEFF_ZERO};
            end
`endif
        end else begin
            state_r      <= state_s;
            rd_en_r      <= rd_en_s;
            rd_addr_r    <= rd_addr_s;
            wr_idx_r     <= wr_idx_s;
            wr_cnt_r     <= wr_cnt_s;
            busy_r       <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
            done_r       <= (state_s == ST_DONE);
            err_r        <= err_s;
            rd_pipe_r[0] <= rd_en_r;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_pipe_r[k] <= rd_pipe_r[k-1];
            end
`ifdef BASEMUL_ACCUMULATE_EN
            acc_r        <= acc_s;
            c_pipe_r[0]  <= c_rd_i;
            for (int k = 1; k < MUL_LAT; k++) begin
                c_pipe_r[k] <= c_pipe_r[k-1];
            end
`endif
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign rd_en_o     = rd_en_r;
    assign rd_addr_o   = rd_addr_r;
    assign mul_valid_o = rd_pipe_r[RD_LAT-1];
    assign wr_en_o     = wr_fire_s;
    assign wr_addr_o   = wr_idx_r;
    assign err_o       = err_r;

    // Operands pass straight through but read as zero outside their valid cycle.
    assign mul_a0_o   = mul_valid_o ? a_rd_i[0] : COEFF_ZERO;
    assign mul_a1_o   = mul_valid_o ? a_rd_i[1] : COEFF_ZERO;
    assign mul_b0_o   = mul_valid_o ? b_rd_i[0] : COEFF_ZERO;
    assign mul_b1_o   = mul_valid_o ? b_rd_i[1] : COEFF_ZERO;
    assign mul_zeta_o = mul_valid_o ? zeta_rd_i : COEFF_ZERO;

    // Write data; in accumulate mode the old C pair arrives aligned with the result.
    always_comb begin
        wr_data_o = {COEFF_ZERO, COEFF_ZERO};
        if (wr_fire_s) begin
`ifdef BASEMUL_ACCUMULATE_EN
            if (acc_r) begin
                wr_data_o = {sum1_s, sum0_s};
            end else begin
                wr_data_o = {mul_c1_i, mul_c0_i};
            end
`else
            wr_data_o = {mul_c1_i, mul_c0_i};
`endif
        end else begin
            wr_data_o = {COEFF_ZERO, COEFF_ZERO};
        end
    end

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Self-checking bench for poly_basemul_ctrl: RAM/ROM and base_case_mul models plus a
// cycle-timeline reference model. Accumulate test is built when BASEMUL_ACCUMULATE_EN is defined.
module tb_poly_basemul_ctrl;
    import poly_arith_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, inj = 1'b0;
    logic busy_o, done_o, rd_en_o, mul_valid_o, mul_valid_i, wr_en_o, err_o;
    pair_addr_t rd_addr_o, wr_addr_o;
    coeff_t [1:0] a_rd, b_rd, wr_data_o;
    coeff_t zeta_rd, mul_a0_o, mul_a1_o, mul_b0_o, mul_b1_o, mul_zeta_o, mul_c0_i, mul_c1_i;
`ifdef BASEMUL_ACCUMULATE_EN
    logic acc_i = 1'b0;
    coeff_t [1:0] c_rd;
`endif

    always #5 clk = ~clk;

    poly_basemul_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
`ifdef BASEMUL_ACCUMULATE_EN
        .acc_i(acc_i), .c_rd_i(c_rd),
`endif
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .a_rd_i(a_rd), .b_rd_i(b_rd), .zeta_rd_i(zeta_rd),
        .mul_valid_o(mul_valid_o), .mul_a0_o(mul_a0_o), .mul_a1_o(mul_a1_o),
        .mul_b0_o(mul_b0_o), .mul_b1_o(mul_b1_o), .mul_zeta_o(mul_zeta_o),
        .mul_valid_i(mul_valid_i), .mul_c0_i(mul_c0_i), .mul_c1_i(mul_c1_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .err_o(err_o)
    );

    int n_tests = 0, n_fail = 0, cyc = 0, wr_count = 0;
    int done_q[$];
    coeff_t a0m[128], a1m[128], b0m[128], b1m[128], zrom[128], g0[128], g1[128];
    coeff_t c0m[128], c1m[128];
    logic c_fill_en = 1'b0;
    coeff_t c_fill_val = 12'd0;

    function automatic coeff_t bm0(int a0, int a1, int b0, int b1, int g);
        return coeff_t'((a0 * b0 + ((a1 * b1) % 3329) * g) % 3329);
    endfunction
    function automatic coeff_t bm1(int a0, int a1, int b0, int b1);
        return coeff_t'((a0 * b1 + a1 * b0) % 3329);
    endfunction
    function automatic int gamma_of(int i);
        int r = 0, p = 1;
        for (int b = 0; b < 7; b++) r |= ((i >> b) & 1) << (6 - b);
        for (int n = 0; n < 2 * r + 1; n++) p = (p * 17) % 3329;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM/ROM read ports, latency 1.
    always @(posedge clk) begin
        if (rd_en_o) begin
            a_rd    <= {a1m[rd_addr_o], a0m[rd_addr_o]};
            b_rd    <= {b1m[rd_addr_o], b0m[rd_addr_o]};
            zeta_rd <= zrom[rd_addr_o];
`ifdef BASEMUL_ACCUMULATE_EN
            c_rd    <= {c1m[rd_addr_o], c0m[rd_addr_o]};
`endif
        end
    end

    // Memory C: bulk fill from the stimulus, else DUT writes.
    always @(posedge clk) begin
        if (c_fill_en) begin
            for (int i = 0; i < 128; i++) begin
                c0m[i] <= c_fill_val;
                c1m[i] <= c_fill_val;
            end
        end else if (wr_en_o) begin
            c0m[wr_addr_o] <= wr_data_o[0];
            c1m[wr_addr_o] <= wr_data_o[1];
        end
    end

    // base_case_mul: two-stage pipeline, cleared by reset.
    logic v1, v2;
    coeff_t p0a, p1a, p0b, p1b;
    always @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            v1  <= mul_valid_o;
            p0a <= bm0(int'(mul_a0_o), int'(mul_a1_o), int'(mul_b0_o), int'(mul_b1_o), int'(mul_zeta_o));
            p1a <= bm1(int'(mul_a0_o), int'(mul_a1_o), int'(mul_b0_o), int'(mul_b1_o));
            v2  <= v1; p0b <= p0a; p1b <= p1a;
        end
    end
    assign mul_valid_i = v2 | inj;
    assign mul_c0_i    = p0b;
    assign mul_c1_i    = p1b;

    // Timeline model: with start accepted in cycle T, reads at T+1..T+128, operands at
    // T+2..T+129, writes at T+4..T+131, done at T+132, idle again at T+133.
    bit active = 1'b0, exp_err = 1'b0, e_rd, e_mv, e_wr, idle_m;
    int t_start = 0, k, j;
    always @(negedge clk) begin
        k = cyc - t_start;
        if (wr_en_o) wr_count++;
        if (done_o) done_q.push_back(cyc);
        if (!rst_n) begin
            chk("wr_en_in_reset", 32'(wr_en_o), 32'd0);
            active  = 1'b0;
            exp_err = 1'b0;
        end else begin
            e_rd = active && k >= 1 && k <= 128;
            e_mv = active && k >= 2 && k <= 129;
            e_wr = active && k >= 4 && k <= 131;
            chk("rd_en", 32'(rd_en_o), 32'(e_rd));
            if (e_rd) chk("rd_addr", 32'(rd_addr_o), 32'(k - 1));
            chk("mul_valid", 32'(mul_valid_o), 32'(e_mv));
            if (e_mv) begin
                j = k - 2;
                chk("mul_a0", 32'(mul_a0_o), 32'(a0m[j]));
                chk("mul_a1", 32'(mul_a1_o), 32'(a1m[j]));
                chk("mul_b0", 32'(mul_b0_o), 32'(b0m[j]));
                chk("mul_b1", 32'(mul_b1_o), 32'(b1m[j]));
                chk("mul_zeta", 32'(mul_zeta_o), 32'(zrom[j]));
            end
            chk("wr_en", 32'(wr_en_o), 32'(e_wr));
            if (e_wr) begin
                chk("wr_addr", 32'(wr_addr_o), 32'(k - 4));
                chk("wr_data", 32'(wr_data_o), 32'({g1[k-4], g0[k-4]}));
            end
            chk("busy", 32'(busy_o), 32'(active && k >= 1 && k <= 131));
            chk("done", 32'(done_o), 32'(active && k == 132));
            chk("err", 32'(err_o), 32'(exp_err));
            idle_m = !active || k >= 133;
            if (inj && (idle_m || k == 132)) exp_err = 1'b1;
            if (idle_m && start_i) begin
                active  = 1'b1;
                t_start = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask
    task automatic pulse_start(output int t);
        start_i = 1'b1; t = cyc; tick(1); start_i = 1'b0;
    endtask
    task automatic fill_c(input coeff_t v);
        c_fill_val = v; c_fill_en = 1'b1; tick(1); c_fill_en = 1'b0;
    endtask
    task automatic load_random();
        for (int i = 0; i < 128; i++) begin
            a0m[i] = coeff_t'($urandom_range(0, 3328)); a1m[i] = coeff_t'($urandom_range(0, 3328));
            b0m[i] = coeff_t'($urandom_range(0, 3328)); b1m[i] = coeff_t'($urandom_range(0, 3328));
        end
    endtask
    task automatic set_gold();
        for (int i = 0; i < 128; i++) begin
            g0[i] = bm0(int'(a0m[i]), int'(a1m[i]), int'(b0m[i]), int'(b1m[i]), int'(zrom[i]));
            g1[i] = bm1(int'(a0m[i]), int'(a1m[i]), int'(b0m[i]), int'(b1m[i]));
        end
    endtask
    task automatic check_c_gold(input string nm);
        for (int i = 0; i < 128; i++) chk(nm, 32'({c1m[i], c0m[i]}), 32'({g1[i], g0[i]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, base, nd;
        for (int i = 0; i < 128; i++) zrom[i] = coeff_t'(gamma_of(i));
        chk("zeta_rom_0", 32'(zrom[0]), 32'd17);
        rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(1);
        chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(wr_data_o), 32'd0);
        chk("rst_mul_a0", 32'(mul_a0_o), 32'd0);

        // A = 1 (a0=1, a1=0), random B: C must equal B.
        load_random();
        for (int i = 0; i < 128; i++) begin a0m[i] = 12'd1; a1m[i] = 12'd0; end
        set_gold(); fill_c(12'd1445);
        base = wr_count;
        pulse_start(t); wait_until(t + 134);
        chk("t1_writes", 32'(wr_count - base), 32'd128);
        chk("t1_done_latency", 32'(done_q[$] - t), 32'd132);
        for (int i = 0; i < 128; i++) chk("t1_c_eq_b", 32'({c1m[i], c0m[i]}), 32'({b1m[i], b0m[i]}));

        // A = B = {-1,-1}: c1 = 2, c0 = 1 + gamma.
        for (int i = 0; i < 128; i++) begin
            a0m[i] = 12'd3328; a1m[i] = 12'd3328; b0m[i] = 12'd3328; b1m[i] = 12'd3328;
        end
        set_gold();
        pulse_start(t); wait_until(t + 134);
        for (int i = 0; i < 128; i++) begin
            chk("t2_c1", 32'(c1m[i]), 32'd2);
            chk("t2_c0", 32'(c0m[i]), 32'((1 + gamma_of(i)) % 3329));
        end
        chk("t2_err", 32'(err_o), 32'd0);

        // start_i re-pulsed mid-run is ignored.
        load_random(); set_gold();
        base = wr_count; nd = done_q.size();
        pulse_start(t);
        wait_until(t + 10); start_i = 1'b1; tick(1); start_i = 1'b0;
        wait_until(t + 60); start_i = 1'b1; tick(1); start_i = 1'b0;
        wait_until(t + 140);
        chk("t3_writes", 32'(wr_count - base), 32'd128);
        chk("t3_done_count", 32'(done_q.size() - nd), 32'd1);
        check_c_gold("t3_c");

        // Reset at T+50: writes 0..45 land, nothing after; then a clean full run.
        load_random(); set_gold(); fill_c(12'd1445);
        base = wr_count;
        pulse_start(t);
        wait_until(t + 50); rst_n = 1'b0; tick(1); rst_n = 1'b1;
        wait_until(t + 140);
        chk("t4_writes_before_rst", 32'(wr_count - base), 32'd46);
        chk("t4_c45", 32'({c1m[45], c0m[45]}), 32'({g1[45], g0[45]}));
        chk("t4_c46_untouched", 32'({c1m[46], c0m[46]}), 32'({12'd1445, 12'd1445}));
        chk("t4_c127_untouched", 32'(c0m[127]), 32'd1445);
        base = wr_count;
        pulse_start(t); wait_until(t + 134);
        chk("t4_rerun_writes", 32'(wr_count - base), 32'd128);
        check_c_gold("t4_c");

        // Back-to-back with start_i held: second start taken at T+133.
        load_random(); set_gold();
        base = wr_count;
        start_i = 1'b1; t = cyc;
        wait_until(t + 134); start_i = 1'b0;
        wait_until(t + 133 + 136);
        chk("t5_writes", 32'(wr_count - base), 32'd256);
        chk("t5_done1", 32'(done_q[done_q.size() - 2] - t), 32'd132);
        chk("t5_done2", 32'(done_q[$] - t), 32'd265);
        check_c_gold("t5_c");

`ifdef BASEMUL_ACCUMULATE_EN
        // C preloaded with 3328, A = 1, B = {1,1}: sums wrap to 0.
        for (int i = 0; i < 128; i++) begin
            a0m[i] = 12'd1; a1m[i] = 12'd0; b0m[i] = 12'd1; b1m[i] = 12'd1;
            g0[i] = 12'd0; g1[i] = 12'd0;
        end
        fill_c(12'd3328);
        acc_i = 1'b1;
        pulse_start(t); wait_until(t + 134);
        acc_i = 1'b0;
        for (int i = 0; i < 128; i++) chk("t6_acc_wrap", 32'({c1m[i], c0m[i]}), 32'd0);
`endif

        // Stray result while idle: write suppressed, err sticky until reset.
        base = wr_count;
        inj = 1'b1; tick(1); inj = 1'b0;
        chk("t7_err_set", 32'(err_o), 32'd1);
        tick(3);
        chk("t7_err_sticky", 32'(err_o), 32'd1);
        chk("t7_no_write", 32'(wr_count - base), 32'd0);
        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
        chk("t7_err_cleared", 32'(err_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
